drop_scheduler: RTL

DROP_SCHEDULER -- requirements
Module: drop_scheduler

---
 rtl/drop_scheduler_pkg.sv | 14 +
 rtl/drop_lane.sv | 45 ++++
 rtl/drop_scheduler.sv | 119 +++++++++++
 3 files changed

// File: rtl/drop_scheduler_pkg.sv
// Shared constants and FSM state type for the falling-letter drop scheduler.
package drop_scheduler_pkg;
  localparam int NUM_LANES = 3;
  localparam int YMAX = 23;
  localparam int LETTER_W = 8;
  localparam int YPOS_W = 5;
  localparam logic [LETTER_W-1:0] BLANK_LETTER = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;
endpackage

// File: rtl/drop_lane.sv
// One falling-letter lane: active flag, letter code and row offset.
module drop_lane
  import drop_scheduler_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                i_restart,
  input  logic                i_freeze,
  input  logic                i_load,
  input  logic                i_step,
  input  logic                i_clear,
  input  logic [LETTER_W-1:0] i_letter,
  output logic                o_active,
  output logic [LETTER_W-1:0] o_letter,
  output logic [YPOS_W-1:0]   o_ypos
);
  logic                r_active;
  logic [LETTER_W-1:0] r_letter;
  logic [YPOS_W-1:0]   r_ypos;

  // Inactive lanes always hold blank/0 so the display needs no extra masking.
  always_ff @(posedge clock) begin
    if (reset || i_restart) begin
      r_active <= 1'b0;
      r_letter <= BLANK_LETTER;
      r_ypos   <= '0;
    end else if (!i_freeze) begin
      if (i_clear) begin
        r_active <= 1'b0;
        r_letter <= BLANK_LETTER;
        r_ypos   <= '0;
      end else if (i_load) begin
        r_active <= 1'b1;
        r_letter <= i_letter;
        r_ypos   <= '0;
      end else if (i_step && r_active && (r_ypos < YPOS_W'(YMAX))) begin
        r_ypos <= r_ypos + YPOS_W'(1);
      end
    end
  end

  assign o_active = r_active;
  assign o_letter = r_letter;
  assign o_ypos   = r_ypos;
endmodule

// File: rtl/drop_scheduler.sv
// Game scheduler: FSM, step counter, score and lane spawn/clear selection.
module drop_scheduler
  import drop_scheduler_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                tick,
  input  logic [3:0]          step_period,
  input  logic                spawn_valid,
  input  logic [LETTER_W-1:0] spawn_letter,
  output logic                spawn_ready,
  input  logic                match_valid,
  input  logic [LETTER_W-1:0] match_letter,
  output logic [LETTER_W-1:0] letter1,
  output logic [LETTER_W-1:0] letter2,
  output logic [LETTER_W-1:0] letter3,
  output logic [YPOS_W-1:0]   ypos1,
  output logic [YPOS_W-1:0]   ypos2,
  output logic [YPOS_W-1:0]   ypos3,
  output logic                game_over,
  output logic [7:0]          score
);
  state_t r_state, w_state_nxt;
  logic [3:0] r_cnt;
  logic [7:0] r_score;

  logic                 w_run, w_restart, w_step, w_bottom;
  logic [3:0]           w_target;
  logic [NUM_LANES-1:0] w_active, w_hit, w_at_bottom, w_clr, w_load;
  logic [LETTER_W-1:0]  w_letter [NUM_LANES];
  logic [YPOS_W-1:0]    w_ypos   [NUM_LANES];

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_run       = (r_state == ST_RUN);
  assign w_target    = (step_period == 4'd0) ? 4'd0 : step_period - 4'd1;
  assign w_step      = w_run && tick && (r_cnt == w_target);
  assign spawn_ready = w_run && !(&w_active);

  always_comb begin
    w_clr = '0;
    w_load = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      w_hit[i]       = w_active[i] && (w_letter[i] == match_letter);
      w_at_bottom[i] = w_active[i] && (w_ypos[i] == YPOS_W'(YMAX));
      if (w_hit[i] && match_valid && w_run) begin
        w_clr    = '0;
        w_clr[i] = 1'b1;
      end
      if (!w_active[i] && spawn_valid && spawn_ready) begin
        w_load    = '0;
        w_load[i] = 1'b1;
      end
    end
  end

  // A lane being cleared this cycle cannot end the game.
  assign w_bottom = w_step && |(w_at_bottom & ~w_clr);

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_restart   = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_bottom) w_state_nxt = ST_OVER;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset || w_restart) begin
      r_cnt   <= '0;
      r_score <= '0;
    end else begin
      if (w_run && tick) r_cnt <= w_step ? 4'd0 : r_cnt + 4'd1;
      if ((|w_clr) && !w_bottom) r_score <= sat_inc8(r_score);
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    drop_lane u_lane (
      .clock     (clock),
      .reset     (reset),
      .i_restart (w_restart),
      .i_freeze  (w_bottom),
      .i_load    (w_load[g]),
      .i_step    (w_step),
      .i_clear   (w_clr[g]),
      .i_letter  (spawn_letter),
      .o_active  (w_active[g]),
      .o_letter  (w_letter[g]),
      .o_ypos    (w_ypos[g])
    );
  end

  assign letter1   = w_letter[0];
  assign letter2   = w_letter[1];
  assign letter3   = w_letter[2];
  assign ypos1     = w_ypos[0];
  assign ypos2     = w_ypos[1];
  assign ypos3     = w_ypos[2];
  assign game_over = (r_state == ST_OVER);
  assign score     = r_score;
endmodule
